ad9280_recv_s_axi: RTL and testbench
====================================

// Module: ad9280_recv_s_axi
// PURPOSE
// ADC receive counterpart of the DAC send IP: generates the AD9280 sample clock, captures 8-bit samples
// into a FIFO and exposes control, status and data to the PS through an AXI4-Lite slave (4 x 32-bit regs).
// Sits in the PL between the ADC pins and the AXI interconnect.
// PARAMETERS
// C_S_AXI_DATA_WIDTH 32  AXI data width (fixed 32)
// C_S_AXI_ADDR_WIDTH 4   AXI byte-address width; decode on addr[3:2]
// CLK_DIV            4   adc_clk half-period in S_AXI_ACLK cycles (>=1)
// FIFO_DEPTH         16  sample FIFO depth, power of 2 (>=2); LVL_W = clog2(FIFO_DEPTH)+1
// PORTS
// S_AXI_ACLK    in  1   single clock for the whole block
// S_AXI_ARESET  in  1   asynchronous, active-high reset
// S_AXI_AWADDR  in  4   write address    | S_AXI_AWVALID in 1 | S_AXI_AWREADY out 1
// S_AXI_WDATA   in  32  write data       | S_AXI_WSTRB in 4   | S_AXI_WVALID in 1 | S_AXI_WREADY out 1
// S_AXI_BRESP   out 2   always 2'b00     | S_AXI_BVALID out 1 | S_AXI_BREADY in 1
// S_AXI_ARADDR  in  4   read address     | S_AXI_ARVALID in 1 | S_AXI_ARREADY out 1
// S_AXI_RDATA   out 32  read data        | S_AXI_RRESP out 2 (always 00) | S_AXI_RVALID out 1 | S_AXI_RREADY in 1
// adc_clk       out 1   ADC sample clock, 50% duty, period 2*CLK_DIV
// adc_data      in  8   ADC parallel output
// BEHAVIOUR
// Reset: all outputs 0, adc_clk 0, all registers 0, FIFO empty, FSM IDLE.
// Registers: 0x00 CTRL RW: [0]EN, [1]FIFO_CLR (write-1 pulse, reads 0). 0x04 LEN RW: [15:0] samples/run, 0=continuous.
//  0x08 STATUS: [0]BUSY [1]DONE [2]EMPTY [3]FULL [4]OVF (sticky, write-1-clears) [31:16] fill level.
//  0x0C DATA RO: {23'b0, valid, sample[7:0]}; valid=0 and data=0 when FIFO empty.
// Write channel: accept only when AWVALID & WVALID & !BVALID; AWREADY and WREADY pulse high together for 1 cycle;
//  register update and BVALID on next edge; BVALID held until BREADY. WSTRB byte enables honoured on CTRL/LEN.
//  Writes to DATA ignored (BRESP still OKAY).
// Read channel: ARREADY 1-cycle pulse when ARVALID & !RVALID; RDATA/RVALID next edge, held stable until RREADY.
//  A DATA read pops the FIFO on the ARREADY cycle (no pop if empty).
// adc_clk: counter toggles adc_clk every CLK_DIV cycles, runs only when EN=1; sample strobe = cycle adc_clk goes 1->0.
// FSM: IDLE -(EN 0->1)-> CAPTURE (cnt=0). CAPTURE: each strobe, push adc_data if !FULL else drop and set OVF;
//  cnt counts dropped samples too. cnt reaches LEN -> DONE (adc_clk stops low). LEN=0 never reaches DONE.
//  EN written 0 in CAPTURE or DONE -> IDLE; FIFO contents kept. DONE stays until EN cleared; re-arm needs 0 then 1.
//  BUSY=1 in CAPTURE; DONE=1 in DONE. LEN writes while BUSY are ignored.
// FIFO: push+pop same cycle -> both occur, level unchanged (also when FULL). FIFO_CLR wins over simultaneous push/pop.
//  Full/empty derived from LVL_W-bit pointers with wrap bit; level = wptr-rptr.
// Reset asserted mid-capture/mid-handshake: immediate return to reset state, pending B/R responses dropped.
// TESTING
// 1 Write LEN=0x0000_0005 with WSTRB=4'b0001 then 4'b0010 of 0x0000_0300 -> LEN reads 0x0000_0305.
// 2 LEN=5, CTRL=1, adc_data ramp 0x10.. -> STATUS=0x0005_0002 after 5 strobes; 5 DATA reads 0x110..0x114, then 0x0.
// 3 LEN=20, depth 16 -> STATUS level 16, FULL=1, OVF=1, DONE=1; write STATUS 0x10 -> OVF=0, level unchanged.
// 4 LEN=0 continuous, DATA read coinciding with strobe at level 3 -> level stays 3, sample order preserved.
// 5 RREADY/BREADY held low 10 cycles -> RDATA/RVALID, BVALID stable; no second accept meanwhile.
// 6 Assert S_AXI_ARESET mid-capture with RVALID pending -> all outputs 0 asynchronously, STATUS=0x0000_0004 after.

Source files
------------

// File: rtl/ad9280_recv_s_axi.sv
// AD9280 ADC receiver: divides the AXI clock down to the ADC sample clock and captures samples into a FIFO.
// The PS reads control, status and FIFO data through a four-register AXI4-Lite slave.
module ad9280_recv_s_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CLK_DIV            = 4,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            adc_clk,
    input  logic [7:0]                      adc_data
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = LVL_W - 1;
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    awready_q, bvalid_q, arready_q, rvalid_q;
    logic [31:0]             rdata_q, rd_mux;
    logic                    en_q, ovf_q;
    logic [15:0]             len_q;
    logic [LVL_W-1:0]        wptr_q, rptr_q, level;
    logic [7:0]              mem [FIFO_DEPTH];
    logic                    adc_clk_q;
    logic [DIV_W-1:0]        div_q;
    logic [1:0]              wr_addr, rd_addr;
    logic                    wr_fire, rd_fire, fifo_clr, empty, full;
    logic                    strobe, push, pop, drop, clk_run;
    logic                    unused_bits;

    assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2]};

    // The cycle in which a ready pulse is high is the handshake cycle; the master still holds addr/data.
    assign wr_fire  = awready_q;
    assign rd_fire  = arready_q;
    assign wr_addr  = S_AXI_AWADDR[3:2];
    assign rd_addr  = S_AXI_ARADDR[3:2];
    assign fifo_clr = wr_fire && (wr_addr == 2'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];

    assign level   = wptr_q - rptr_q;
    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign clk_run = (state_q == ST_CAPTURE) && en_q;
    assign strobe  = clk_run && adc_clk_q && (div_q == DIV_W'(CLK_DIV - 1));
    assign pop     = rd_fire && (rd_addr == 2'd3) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the sample.
    assign push    = strobe && (!full || pop);
    assign drop    = strobe && full && !pop;

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign adc_clk       = adc_clk_q;

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
            if (wr_fire)
                bvalid_q <= 1'b1;
            else if (S_AXI_BREADY)
                bvalid_q <= 1'b0;
            arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            en_q  <= 1'b0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_fire && wr_addr == 2'd0 && S_AXI_WSTRB[0])
                en_q <= S_AXI_WDATA[0];
            // Run length is frozen while a capture is in progress.
            if (wr_fire && wr_addr == 2'd1 && state_q != ST_CAPTURE) begin
                if (S_AXI_WSTRB[0]) len_q[7:0]  <= S_AXI_WDATA[7:0];
                if (S_AXI_WSTRB[1]) len_q[15:8] <= S_AXI_WDATA[15:8];
            end
            if (drop)
                ovf_q <= 1'b1;
            else if (wr_fire && wr_addr == 2'd2 && S_AXI_WSTRB[0] && S_AXI_WDATA[4])
                ovf_q <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            2'd0: rd_mux[0] = en_q;
            2'd1: rd_mux[15:0] = len_q;
            2'd2: begin
                rd_mux[0]     = (state_q == ST_CAPTURE);
                rd_mux[1]     = (state_q == ST_DONE);
                rd_mux[2]     = empty;
                rd_mux[3]     = full;
                rd_mux[4]     = ovf_q;
                rd_mux[31:16] = 16'(level);
            end
            default: if (!empty) rd_mux[8:0] = {1'b1, mem[rptr_q[PTR_W-1:0]]};
        endcase
    end

    // Clear has priority over any push or pop landing in the same cycle.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (fifo_clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push && !fifo_clr)
            mem[wptr_q[PTR_W-1:0]] <= adc_data;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            div_q     <= '0;
            adc_clk_q <= 1'b0;
        end else if (clk_run) begin
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
                div_q     <= '0;
                adc_clk_q <= ~adc_clk_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end else begin
            div_q     <= '0;
            adc_clk_q <= 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // IDLE can only see EN=1 after a fresh 0->1 write, since every path back to IDLE needs EN=0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end
            end
            ST_CAPTURE: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (strobe) begin
                    cnt_d = cnt_q + 16'd1;
                    if (len_q != 16'd0 && cnt_d == len_q)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!en_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ad9280_recv_s_axi.sv
// Directed bench for ad9280_recv_s_axi: a register vector table followed by hand-written
// capture, overflow, concurrent pop/push, back-pressure and asynchronous reset sequences.
module tb_ad9280_recv_s_axi;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int NVEC       = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [7:0]  adc_data = '0;
    logic        awready, wready, bvalid, arready, rvalid, adc_clk;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int vec_count = 0;
    int miscompares = 0;

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[NVEC];

    ad9280_recv_s_axi #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),
        .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .adc_clk(adc_clk),
        .adc_data(adc_data)
    );

    always #5 clk = ~clk;

    // The ADC presents the next ramp value after each falling sample clock.
    initial begin
        forever begin
            @(negedge adc_clk);
            adc_data = adc_data + 8'd1;
        end
    end

    function automatic logic [31:0] outBits();
        return 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp, adc_clk});
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        vec_count++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting, expected handshake", name);
    endtask

    task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp);
        int n;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        if (!awready) begin
            awvalid = 1'b0; wvalid = 1'b0; resp = 2'b11;
            timeoutFail("awready");
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (!bvalid) begin
            resp = 2'b11;
            timeoutFail("bvalid");
            return;
        end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        logic [1:0] resp;
        axiWrite(addr, data, 4'hF, resp);
    endtask

    task automatic axiRead(input logic [3:0] addr, output logic [31:0] data);
        int n;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
        if (!arready) begin
            arvalid = 1'b0; data = 32'hDEAD_BEEF;
            timeoutFail("arready");
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (!rvalid) begin
            data = 32'hDEAD_BEEF;
            timeoutFail("rvalid");
            return;
        end
        data = rdata;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic rdCheck(input string name, input logic [3:0] addr, input logic [31:0] expected);
        logic [31:0] d;
        axiRead(addr, d);
        checkOutput(name, d, expected);
    endtask

    // Returns one step after the clock edge on which the n-th falling sample clock appeared.
    task automatic waitFalls(input int n);
        int seen, cyc;
        logic prev;
        seen = 0; cyc = 0; prev = adc_clk;
        while (seen < n && cyc < n * 2 * CLK_DIV + 40) begin
            @(posedge clk); #1; cyc++;
            if (prev && !adc_clk) seen++;
            prev = adc_clk;
        end
        if (seen < n) timeoutFail("adc_clk falls");
    endtask

    task automatic applyStimulus(input int idx);
        logic [1:0]  resp;
        logic [31:0] d;
        if (vecs[idx].is_wr) begin
            axiWrite(vecs[idx].addr, vecs[idx].wdata, vecs[idx].wstrb, resp);
            checkOutput($sformatf("vec%0d bresp", idx), 32'(resp), vecs[idx].exp);
        end else begin
            axiRead(vecs[idx].addr, d);
            checkOutput($sformatf("vec%0d rdata", idx), d, vecs[idx].exp);
        end
    endtask

    initial begin
        int bad, extra;
        logic [31:0] held;

        vecs[0]  = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 4'h4, 32'h0,          4'h0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 4'h8, 32'h0,          4'h0, 32'h0000_0004};
        vecs[3]  = '{1'b0, 4'hC, 32'h0,          4'h0, 32'h0000_0000};
        vecs[4]  = '{1'b1, 4'h4, 32'h0000_0005,  4'h1, 32'h0};
        vecs[5]  = '{1'b1, 4'h4, 32'h0000_0300,  4'h2, 32'h0};
        vecs[6]  = '{1'b0, 4'h4, 32'h0,          4'h0, 32'h0000_0305};
        vecs[7]  = '{1'b1, 4'h4, 32'hABCD_1234,  4'hF, 32'h0};
        vecs[8]  = '{1'b0, 4'h4, 32'h0,          4'h0, 32'h0000_1234};
        vecs[9]  = '{1'b1, 4'h4, 32'h0000_FFFF,  4'h0, 32'h0};
        vecs[10] = '{1'b0, 4'h4, 32'h0,          4'h0, 32'h0000_1234};
        vecs[11] = '{1'b1, 4'hC, 32'h0000_00FF,  4'hF, 32'h0};
        vecs[12] = '{1'b0, 4'hC, 32'h0,          4'h0, 32'h0000_0000};
        vecs[13] = '{1'b1, 4'h0, 32'h0000_0002,  4'h1, 32'h0};
        vecs[14] = '{1'b0, 4'h0, 32'h0,          4'h0, 32'h0000_0000};
        vecs[15] = '{1'b0, 4'h8, 32'h0,          4'h0, 32'h0000_0004};
        vecs[16] = '{1'b1, 4'h8, 32'h0000_0010,  4'h1, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs", outBits(), 32'h0);
        checkOutput("reset rdata", rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) applyStimulus(i);

        // Five-sample run from a ramp starting at 0x10.
        wr(4'h4, 32'd5);
        adc_data = 8'h10;
        wr(4'h0, 32'h1);
        waitFalls(5);
        repeat (3) @(posedge clk);
        #1;
        rdCheck("run5 status", 4'h8, 32'h0005_0002);
        checkOutput("run5 adc_clk low", 32'(adc_clk), 32'h0);
        for (int i = 0; i < 5; i++) rdCheck($sformatf("run5 data%0d", i), 4'hC, 32'h110 + 32'(i));
        rdCheck("run5 data empty", 4'hC, 32'h0);
        rdCheck("run5 status drained", 4'h8, 32'h0000_0006);

        // Twenty samples into a 16-deep FIFO.
        wr(4'h0, 32'h0);
        wr(4'h0, 32'h2);
        wr(4'h4, 32'd20);
        adc_data = 8'h80;
        wr(4'h0, 32'h1);
        waitFalls(20);
        repeat (3) @(posedge clk);
        #1;
        rdCheck("ovf status", 4'h8, 32'h0010_001A);
        checkOutput("ovf adc_clk parked", 32'(adc_clk), 32'h0);
        wr(4'h8, 32'h10);
        rdCheck("ovf cleared", 4'h8, 32'h0010_000A);
        rdCheck("ovf first sample", 4'hC, 32'h0000_0180);
        rdCheck("ovf after pop", 4'h8, 32'h000F_0002);

        // Continuous capture with a DATA pop landing on the same edge as the 4th sample.
        wr(4'h0, 32'h0);
        wr(4'h0, 32'h2);
        wr(4'h8, 32'h10);
        wr(4'h4, 32'h0);
        adc_data = 8'h40;
        wr(4'h0, 32'h1);
        wr(4'h4, 32'd7);
        waitFalls(1);
        rdCheck("cont busy status", 4'h8, 32'h0001_0001);
        waitFalls(2);
        repeat (6) @(posedge clk);
        #1;
        rdCheck("cont pop on strobe", 4'hC, 32'h0000_0140);
        wr(4'h0, 32'h0);
        rdCheck("cont level kept", 4'h8, 32'h0003_0000);
        rdCheck("len frozen while busy", 4'h4, 32'h0);
        for (int i = 0; i < 3; i++) rdCheck($sformatf("cont order%0d", i), 4'hC, 32'h141 + 32'(i));
        rdCheck("cont empty", 4'h8, 32'h0000_0004);

        // Read response held while RREADY is low, with ARVALID still asserted.
        wr(4'h4, 32'h0000_00A5);
        araddr = 4'h4; arvalid = 1'b1;
        for (int n = 0; n < 20 && !arready; n++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        held = rdata;
        bad = 0; extra = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (!rvalid || rdata !== held) bad++;
            if (arready) extra++;
        end
        checkOutput("R held data", held, 32'h0000_00A5);
        checkOutput("R stable", 32'(bad), 32'h0);
        checkOutput("R no second accept", 32'(extra), 32'h0);
        arvalid = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        checkOutput("R released", 32'(rvalid), 32'h0);

        // Write response held while BREADY is low; a second accept would load 0x77.
        awaddr = 4'h4; wdata = 32'h5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 20 && !awready; n++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        wdata = 32'h77;
        bad = 0; extra = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (!bvalid) bad++;
            if (awready || wready) extra++;
        end
        checkOutput("B stable", 32'(bad), 32'h0);
        checkOutput("B no second accept", 32'(extra), 32'h0);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checkOutput("B released", 32'(bvalid), 32'h0);
        rdCheck("B single write", 4'h4, 32'h0000_005A);

        // Asynchronous reset mid-capture with a read response outstanding.
        wr(4'h4, 32'h0);
        adc_data = 8'h00;
        wr(4'h0, 32'h1);
        waitFalls(2);
        araddr = 4'h8; arvalid = 1'b1;
        for (int n = 0; n < 20 && !arready; n++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        checkOutput("rst rvalid pending", 32'(rvalid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst async outputs", outBits(), 32'h0);
        checkOutput("rst async rdata", rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rdCheck("rst status", 4'h8, 32'h0000_0004);
        rdCheck("rst ctrl", 4'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
